// File: rtl/display_sequencer.sv
// display_sequencer: title / play / end-fade / end-hold screen sequencer.
// Blends the game picture into the end frame over 2**FADE_SHIFT frames.
// Holds the end frame for at least HOLD_FRAMES frames before a restart is accepted.
// Optional feature: define END_BLINK_EN to blink the end frame while holding
// (16 frames on, 16 frames off).
module display_sequencer #(
    parameter int FADE_SHIFT  = 4,
    parameter int HOLD_FRAMES = 120
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic        i_start_btn,
    input  logic        i_game_over,
    input  logic        i_p1_win,
    input  logic [23:0] i_title_rgb,
    input  logic [23:0] i_game_rgb,
    input  logic [23:0] i_end_rgb,
    output logic        o_is_p1_win,
    output logic [1:0]  o_state,
    output logic        o_game_en,
    output logic [23:0] o_rgb
);

    localparam int FADE_N = 1 << FADE_SHIFT;
    // The fade counter is one bit wider than needed so that N-k is representable.
    localparam int KW     = FADE_SHIFT + 1;
    localparam int HW     = $clog2(HOLD_FRAMES + 1);
    // Wide enough for g*(N-k) + e*k without overflow.
    localparam int BW     = 8 + FADE_SHIFT + 1;

    localparam logic [KW-1:0] K_LAST   = KW'(FADE_N - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        TITLE    = 2'd0,
        PLAY     = 2'd1,
        END_FADE = 2'd2,
        END_HOLD = 2'd3
    } state_t;

    state_t        state_r, state_nx;
    logic [KW-1:0] k_r, k_nx;
    logic [HW-1:0] hold_r, hold_nx;
    logic          win_r, win_nx;
    logic          game_en_r;
    logic [23:0]   rgb_r, rgb_nx;
`ifdef END_BLINK_EN
    logic [4:0]    blink_r, blink_nx;
`endif

    // Blend one 8-bit channel: (g*(N-k) + e*k) >> FADE_SHIFT, truncating.
    function automatic logic [7:0] fade_channel(input logic [7:0] g,
                                                 input logic [7:0] e,
                                                 input logic [KW-1:0] k);
        logic [BW-1:0] gw;
        logic [BW-1:0] ew;
        logic [BW-1:0] kw;
        logic [BW-1:0] nk;
        logic [BW-1:0] acc;
        gw  = BW'(g);
        ew  = BW'(e);
        kw  = BW'(k);
        nk  = BW'(FADE_N) - kw;
        acc = (gw * nk) + (ew * kw);
        return 8'(acc >> FADE_SHIFT);
    endfunction

    // Blend all three channels of a pixel.
    function automatic logic [23:0] fade_pixel(input logic [23:0] g,
                                               input logic [23:0] e,
                                               input logic [KW-1:0] k);
        return {fade_channel(g[23:16], e[23:16], k),
                fade_channel(g[15:8],  e[15:8],  k),
                fade_channel(g[7:0],   e[7:0],   k)};
    endfunction

    // State register and all registered outputs; synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r   <= TITLE;
            k_r       <= {KW{1'b0}};
            hold_r    <= {HW{1'b0}};
            win_r     <= 1'b0;
            game_en_r <= 1'b0;
            rgb_r     <= 24'h000000;
`ifdef END_BLINK_EN
            blink_r   <= 5'd0;
`endif
        end else begin
            state_r   <= state_nx;
            k_r       <= k_nx;
            hold_r    <= hold_nx;
            win_r     <= win_nx;
            game_en_r <= (state_nx == PLAY);
            rgb_r     <= rgb_nx;
`ifdef END_BLINK_EN
            blink_r   <= blink_nx;
`endif
        end
    end

    // Next-state logic plus fade, hold and blink counter updates.
    always_comb begin
        state_nx = state_r;
        k_nx     = k_r;
        hold_nx  = hold_r;
        win_nx   = win_r;
`ifdef END_BLINK_EN
        blink_nx = blink_r;
`endif
        case (state_r)
            TITLE: begin
                if (i_start_btn) begin
                    state_nx = PLAY;
                end else begin
                    state_nx = TITLE;
                end
            end
            PLAY: begin
                // Game-over wins over a coincident frame pulse: k starts at 0.
                if (i_game_over) begin
                    win_nx   = i_p1_win;
                    k_nx     = {KW{1'b0}};
                    state_nx = END_FADE;
                end else begin
                    state_nx = PLAY;
                end
            end
            END_FADE: begin
                if (i_frame_start) begin
                    if (k_r == K_LAST) begin
                        state_nx = END_HOLD;
                        hold_nx  = {HW{1'b0}};
`ifdef END_BLINK_EN
                        blink_nx = 5'd0;
`endif
                    end else begin
                        k_nx = k_r + {{(KW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nx = END_FADE;
                end
            end
            END_HOLD: begin
                if (i_frame_start) begin
                    if (hold_r != HOLD_MAX) begin
                        hold_nx = hold_r + {{(HW-1){1'b0}}, 1'b1};
                    end else begin
                        hold_nx = HOLD_MAX;
                    end
`ifdef END_BLINK_EN
                    blink_nx = blink_r + 5'd1;
`endif
                end else begin
                    hold_nx = hold_r;
                end
                if (i_start_btn && (hold_r == HOLD_MAX)) begin
                    state_nx = TITLE;
                end else begin
                    state_nx = END_HOLD;
                end
            end
            default: begin
                state_nx = TITLE;
            end
        endcase
    end

    // Pixel source for the state being entered, so o_rgb lines up with o_state.
    always_comb begin
        rgb_nx = 24'h000000;
        case (state_nx)
            TITLE:    rgb_nx = i_title_rgb;
            PLAY:     rgb_nx = i_game_rgb;
            END_FADE: rgb_nx = fade_pixel(i_game_rgb, i_end_rgb, k_nx);
            END_HOLD: begin
`ifdef END_BLINK_EN
                if (blink_nx[4]) begin
                    rgb_nx = 24'h000000;
                end else begin
                    rgb_nx = i_end_rgb;
                end
`else
                rgb_nx = i_end_rgb;
`endif
            end
            default:  rgb_nx = 24'h000000;
        endcase
    end

    assign o_state     = state_r;
    assign o_game_en   = game_en_r;
    assign o_is_p1_win = win_r;
    assign o_rgb       = rgb_r;

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer: directed sequence with randomized
// pixels and frame gaps, checked against a behavioural screen model.
module tb_display_sequencer;

    localparam int FADE_SHIFT  = 4;
    localparam int HOLD_FRAMES = 120;
    localparam int N           = 1 << FADE_SHIFT;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_frame_start;
    logic        i_start_btn;
    logic        i_game_over;
    logic        i_p1_win;
    logic [23:0] i_title_rgb;
    logic [23:0] i_game_rgb;
    logic [23:0] i_end_rgb;
    logic        o_is_p1_win;
    logic [1:0]  o_state;
    logic        o_game_en;
    logic [23:0] o_rgb;

    int vectors     = 0;
    int miscompares = 0;
    bit rnd_rgb     = 1'b1;

    // Reference model: screen (0 title,1 play,2 fade,3 hold), fade step, hold frames.
    int          m_screen = 0;
    int          m_k      = 0;
    int          m_hold   = 0;
    int          m_blink  = 0;
    bit          m_win    = 1'b0;
    logic [23:0] m_rgb    = 24'h000000;

    display_sequencer #(
        .FADE_SHIFT (FADE_SHIFT),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_start(i_frame_start),
        .i_start_btn  (i_start_btn),
        .i_game_over  (i_game_over),
        .i_p1_win     (i_p1_win),
        .i_title_rgb  (i_title_rgb),
        .i_game_rgb   (i_game_rgb),
        .i_end_rgb    (i_end_rgb),
        .o_is_p1_win  (o_is_p1_win),
        .o_state      (o_state),
        .o_game_en    (o_game_en),
        .o_rgb        (o_rgb)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [23:0] blend(input logic [23:0] g, input logic [23:0] e, input int k);
        logic [23:0] r;
        int gc;
        int ec;
        r = 24'h000000;
        for (int c = 0; c < 3; c++) begin
            gc = int'((g >> (8 * c)) & 24'h0000FF);
            ec = int'((e >> (8 * c)) & 24'h0000FF);
            r[8*c +: 8] = 8'((gc * (N - k) + ec * k) / N);
        end
        return r;
    endfunction

    task automatic model_edge(input bit rst_n, input bit fs, input bit sb, input bit go, input bit win);
        int nxt;
        if (!rst_n) begin
            m_screen = 0; m_k = 0; m_hold = 0; m_blink = 0; m_win = 1'b0;
            m_rgb = 24'h000000;
            return;
        end
        nxt = m_screen;
        case (m_screen)
            0: if (sb) nxt = 1;
            1: if (go) begin m_win = win; m_k = 0; nxt = 2; end
            2: if (fs) begin
                   if (m_k == N - 1) begin nxt = 3; m_hold = 0; m_blink = 0; end
                   else m_k = m_k + 1;
               end
            default: begin
                if (sb && m_hold == HOLD_FRAMES) nxt = 0;
                if (fs) begin
                    m_hold  = (m_hold < HOLD_FRAMES) ? m_hold + 1 : HOLD_FRAMES;
                    m_blink = (m_blink + 1) % 32;
                end
            end
        endcase
        m_screen = nxt;
        case (m_screen)
            0: m_rgb = i_title_rgb;
            1: m_rgb = i_game_rgb;
            2: m_rgb = blend(i_game_rgb, i_end_rgb, m_k);
            default: begin
`ifdef END_BLINK_EN
                m_rgb = (m_blink >= 16) ? 24'h000000 : i_end_rgb;
`else
                m_rgb = i_end_rgb;
`endif
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance model and DUT, compare all outputs.
    task automatic tick(input bit rst_n, input bit fs, input bit sb, input bit go, input bit win);
        i_rst_n       = rst_n;
        i_frame_start = fs;
        i_start_btn   = sb;
        i_game_over   = go;
        i_p1_win      = win;
        if (rnd_rgb) begin
            i_title_rgb = 24'($urandom);
            i_game_rgb  = 24'($urandom);
            i_end_rgb   = 24'($urandom);
        end
        model_edge(rst_n, fs, sb, go, win);
        @(posedge i_clk);
        #1;
        check("state",   {22'd0, o_state},     24'(m_screen));
        check("game_en", {23'd0, o_game_en},   {23'd0, (m_screen == 1)});
        check("p1_win",  {23'd0, o_is_p1_win}, {23'd0, m_win});
        check("rgb",     o_rgb,                m_rgb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(int'($urandom_range(0, 2)));
    endtask

    initial begin
        logic [23:0] g7;
        i_rst_n = 1'b0; i_frame_start = 1'b0; i_start_btn = 1'b0;
        i_game_over = 1'b0; i_p1_win = 1'b0;
        i_title_rgb = 24'h0; i_game_rgb = 24'h0; i_end_rgb = 24'h0;

        // Reset, then idle in title with stray game-over pulses (ignored).
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_state", {22'd0, o_state}, 24'd0);
        check("rst_rgb", o_rgb, 24'h000000);
        idle(3);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("title_ignores_go", {22'd0, o_state}, 24'd0);

        // Start -> play; start pulses in play are ignored.
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("play_en", {23'd0, o_game_en}, 24'd1);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Game over with p1 winning, fixed red game / blue end pixels.
        rnd_rgb = 1'b0;
        i_game_rgb = 24'hFF0000; i_end_rgb = 24'h0000FF; i_title_rgb = 24'h123456;
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("fade_entry", {22'd0, o_state}, 24'd2);
        check("fade_en_low", {23'd0, o_game_en}, 24'd0);
        check("fade_win", {23'd0, o_is_p1_win}, 24'd1);
        check("fade_k0", o_rgb, 24'hFF0000);

        // Fade with ignored start/game-over (win=0) pulses between frames.
        for (int f = 1; f <= 16; f++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (f == 8) check("fade_k8", o_rgb, 24'h7F007F);
            if (f == 15) check("fade_k15_state", {22'd0, o_state}, 24'd2);
            tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("hold_entry", {22'd0, o_state}, 24'd3);

        // Hold: early restart ignored, restart accepted once saturated.
        rnd_rgb = 1'b1;
        for (int f = 1; f <= 125; f++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef END_BLINK_EN
            if (f < 32) check("blink", o_rgb, (f < 16) ? i_end_rgb : 24'h000000);
`endif
            idle(int'($urandom_range(0, 2)));
            if (f == 50) begin
                tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                check("early_restart", {22'd0, o_state}, 24'd3);
            end
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("restart", {22'd0, o_state}, 24'd0);
        check("restart_win", {23'd0, o_is_p1_win}, 24'd1);
        idle(2);

        // Game over coincident with frame start: fade entered at k=0, p2 wins.
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        rnd_rgb = 1'b0;
        g7 = 24'($urandom);
        i_game_rgb = g7; i_end_rgb = 24'($urandom);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("coinc_state", {22'd0, o_state}, 24'd2);
        check("coinc_rgb", o_rgb, g7);
        check("coinc_win", {23'd0, o_is_p1_win}, 24'd0);
        rnd_rgb = 1'b1;
        frame();

        // Reset mid-fade at k=5 after a p1 win.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int f = 0; f < 5; f++) frame();
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("midfade_rst_state", {22'd0, o_state}, 24'd0);
        check("midfade_rst_rgb", o_rgb, 24'h000000);
        check("midfade_rst_win", {23'd0, o_is_p1_win}, 24'd0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 The block SHALL have parameter FADE_SHIFT, default 4, giving a fade length of 2**FADE_SHIFT frames.
REQ-002 The block SHALL have parameter HOLD_FRAMES, default 120, giving the minimum number of frames in END_HOLD before restart is accepted.
REQ-003 The block SHALL have port i_clk, input, 1 bit: system clock, the only clock.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port i_frame_start, input, 1 bit: one-cycle pulse at the start of each video frame.
REQ-006 The block SHALL have port i_start_btn, input, 1 bit: one-cycle debounced start/restart pulse.
REQ-007 The block SHALL have port i_game_over, input, 1 bit: one-cycle pulse from game logic.
REQ-008 The block SHALL have port i_p1_win, input, 1 bit: winner flag, valid only while i_game_over is high.
REQ-009 The block SHALL have ports i_title_rgb, i_game_rgb and i_end_rgb, input, 24 bits each: pixel colours from the title ROM, the game renderer and the end-frame ROM for the current pixel.
REQ-010 The block SHALL have port o_is_p1_win, output, 1 bit: latched winner, driven to the end-frame ROM.
REQ-011 The block SHALL have port o_state, output, 2 bits: TITLE=0, PLAY=1, END_FADE=2, END_HOLD=3.
REQ-012 The block SHALL have port o_game_en, output, 1 bit: game logic run enable, high only in PLAY.
REQ-013 The block SHALL have port o_rgb, output, 24 bits: registered selected or blended pixel.

Function
REQ-014 The state register SHALL change only on rising i_clk edges; all outputs SHALL be registered.
REQ-015 In TITLE, i_start_btn SHALL move the state to PLAY on the next cycle; i_game_over SHALL be ignored.
REQ-016 In PLAY, i_game_over SHALL latch i_p1_win into o_is_p1_win, clear the fade counter k to 0 and move to END_FADE; i_start_btn SHALL be ignored.
REQ-017 In END_FADE, each i_frame_start SHALL increment k; when k reaches 2**FADE_SHIFT-1 and i_frame_start is high, the state SHALL move to END_HOLD and the hold counter SHALL clear.
REQ-018 If i_game_over and i_frame_start are high in the same PLAY cycle, the transition SHALL win and k SHALL equal 0 at END_FADE entry.
REQ-019 In END_HOLD, each i_frame_start SHALL increment the hold counter, saturating at HOLD_FRAMES.
REQ-020 In END_HOLD, i_start_btn SHALL move the state to TITLE only when the hold counter equals HOLD_FRAMES; otherwise it SHALL be ignored.
REQ-021 i_start_btn and i_game_over SHALL be ignored in END_FADE.
REQ-022 o_is_p1_win SHALL hold its latched value through END_FADE, END_HOLD and TITLE until the next game-over latch.
REQ-023 o_rgb SHALL be i_title_rgb in TITLE, i_game_rgb in PLAY and i_end_rgb in END_HOLD, with 1-cycle latency from the rgb inputs.
REQ-024 In END_FADE, each 8-bit channel of o_rgb SHALL be (g*(N-k) + e*k) >> FADE_SHIFT, where N = 2**FADE_SHIFT, g is the i_game_rgb channel and e is the i_end_rgb channel.
REQ-025 The fade calculation SHALL use an intermediate width of 8+FADE_SHIFT+1 bits so that it never overflows, and SHALL use truncating division.
REQ-026 o_state and o_game_en SHALL reflect the current state register with no extra delay relative to each other.

Reset
REQ-027 When i_rst_n is low at a clock edge, the block SHALL set state TITLE, o_state=0, o_game_en=0, o_is_p1_win=0, o_rgb=24'h000000, k=0, hold counter 0 and blink counter 0.
REQ-028 A reset asserted in any state, including mid-fade, SHALL take effect at that edge and discard all pending events.

Configuration
REQ-029 When the macro END_BLINK_EN is defined, a 5-bit blink counter SHALL increment on i_frame_start in END_HOLD and clear on END_HOLD entry.
REQ-030 With END_BLINK_EN defined, o_rgb in END_HOLD SHALL be i_end_rgb when blink counter bit 4 is 0 and 24'h000000 when it is 1 (16 frames on, 16 frames off).
REQ-031 Without END_BLINK_EN, o_rgb in END_HOLD SHALL be steadily i_end_rgb and the blink counter SHALL not exist.

Verification
REQ-032 The bench SHALL drive reset, then i_start_btn, then i_game_over with i_p1_win=1, and check: o_state 0 -> 1 -> 2, o_game_en 0 -> 1 -> 0, o_is_p1_win=1.
REQ-033 The bench SHALL run the fade with FADE_SHIFT=4, game=24'hFF0000 and end=24'h0000FF, and check: at k=0 o_rgb=24'hFF0000; at k=8 o_rgb=24'h7F007F; END_HOLD after the 16th frame pulse.
REQ-034 The bench SHALL pulse i_start_btn in END_HOLD after 50 frames and check that it is ignored; after 120 frames it SHALL return the state to TITLE with o_is_p1_win still 1.
REQ-035 The bench SHALL assert i_game_over and i_frame_start in the same PLAY cycle and check END_FADE entry with k=0 (o_rgb equals the game pixel).
REQ-036 The bench SHALL assert reset during END_FADE at k=5 and check o_state=0, o_rgb=0 and o_is_p1_win=0 on the next cycle.
REQ-037 With END_BLINK_EN defined, the bench SHALL check in END_HOLD that o_rgb is i_end_rgb for frames 0-15 and 24'h000000 for frames 16-31.
